// File: rtl/seven_seg_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_capture_if
// Description : Bundle of the seven-segment capture signals. The master side
//               drives the display lines (an, seg[, dp]). The slave side, which
//               is the capture block, returns the decoded results.
//               Signals:
//                 an          anode strobes, active-low, one per digit
//                 seg         cathodes {a,b,c,d,e,f,g}, active-low
//                 hex_out     captured nibbles, digit i at [4i+3:4i]
//                 digit_valid per-slot "holds a valid decode" flags
//                 bad_pattern one-cycle pulse, undecodable stable pattern
//                 ghost_err   one-cycle pulse, several anodes low and stable
//                 frame_done  one-cycle pulse, all slots captured
//                 dp / dp_out decimal point in and out, only present when
//                             SEVSEG_DP_CAPTURE_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_capture_if #(
    parameter int NUM_DIGITS = 8
);
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic [4*NUM_DIGITS-1:0] hex_out;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    bad_pattern;
    logic                    ghost_err;
    logic                    frame_done;
`ifdef SEVSEG_DP_CAPTURE_EN
    logic                    dp;
    logic [NUM_DIGITS-1:0]   dp_out;

    modport master (
        output an, seg, dp,
        input  hex_out, digit_valid, bad_pattern, ghost_err, frame_done, dp_out
    );
    modport slave (
        input  an, seg, dp,
        output hex_out, digit_valid, bad_pattern, ghost_err, frame_done, dp_out
    );
`else
    modport master (
        output an, seg,
        input  hex_out, digit_valid, bad_pattern, ghost_err, frame_done
    );
    modport slave (
        input  an, seg,
        output hex_out, digit_valid, bad_pattern, ghost_err, frame_done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/seven_seg_capture.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_capture
// Description : Reader for a multiplexed, active-low seven-segment display.
//               The {an,seg} lines must stay identical for STABLE_CYCLES
//               consecutive clock edges. After that the pattern is evaluated
//               once. A single low anode with a known segment code is written
//               into that digit's slot. An unknown code raises bad_pattern.
//               Several low anodes raise ghost_err. frame_done pulses once
//               every slot has been captured validly since the previous frame.
//               Optional feature macro: SEVSEG_DP_CAPTURE_EN. It adds dp to
//               the stability comparison and records ~dp per digit in dp_out.
//               Ports:
//                 clk   system clock, rising edge
//                 reset asynchronous active-high reset
//                 bus   seven_seg_capture_if.slave (see interface header)
// Parameters  : NUM_DIGITS    - number of anodes / slots (default 8)
//               STABLE_CYCLES - edges of stability before capture (2..255)
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_capture #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    seven_seg_capture_if.slave  bus
);

`ifdef SEVSEG_DP_CAPTURE_EN
    localparam int c_IN_W = NUM_DIGITS + 8;
`else
    localparam int c_IN_W = NUM_DIGITS + 7;
`endif
    localparam logic [7:0]            c_STABLE = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] c_ONE    = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [7:0]              r_cnt;
    logic [7:0]              w_cnt_next;
    logic                    w_eval;

    logic [c_IN_W-1:0]       w_in;
    logic [c_IN_W-1:0]       r_in_q;
    logic                    w_change;

    logic [NUM_DIGITS-1:0]   w_low;
    logic                    w_any;
    logic                    w_multi;
    logic [4:0]              w_dec;
    logic                    w_dec_valid;
    logic [3:0]              w_dec_hex;
    logic [NUM_DIGITS-1:0]   w_seen_upd;

    logic [4*NUM_DIGITS-1:0] r_hex;
    logic [NUM_DIGITS-1:0]   r_dv;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic                    r_bad;
    logic                    r_ghost;
    logic                    r_frame;
`ifdef SEVSEG_DP_CAPTURE_EN
    logic [NUM_DIGITS-1:0]   r_dp_out;
`endif

    // Inverse of the hex-to-segment encoder. Result is {valid, nibble}.
    function automatic logic [4:0] f_decode(input logic [6:0] s);
        logic [4:0] v;
        case (s)
            7'b0000001: v = 5'h10;
            7'b1001111: v = 5'h11;
            7'b0010010: v = 5'h12;
            7'b0000110: v = 5'h13;
            7'b1001100: v = 5'h14;
            7'b0100100: v = 5'h15;
            7'b0100000: v = 5'h16;
            7'b0001111: v = 5'h17;
            7'b0000000: v = 5'h18;
            7'b0001100: v = 5'h19;
            7'b0001000: v = 5'h1A;
            7'b1100000: v = 5'h1B;
            7'b0110001: v = 5'h1C;
            7'b1000010: v = 5'h1D;
            7'b0110000: v = 5'h1E;
            7'b0111000: v = 5'h1F;
            default:    v = 5'h00;
        endcase
        return v;
    endfunction

`ifdef SEVSEG_DP_CAPTURE_EN
    assign w_in = {bus.an, bus.seg, bus.dp};
`else
    assign w_in = {bus.an, bus.seg};
`endif
    assign w_change = (w_in != r_in_q);

    // Active-high digit selects. x & (x-1) clears the lowest set bit, so a
    // non-zero result means two or more anodes are low together.
    assign w_low       = ~bus.an;
    assign w_any       = |w_low;
    assign w_multi     = |(w_low & (w_low - c_ONE));
    assign w_dec       = f_decode(bus.seg);
    assign w_dec_valid = w_dec[4];
    assign w_dec_hex   = w_dec[3:0];
    assign w_seen_upd  = r_seen | w_low;

    // In reset, in_q holds all ones, so any driven pattern counts as a change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_q <= '1;
        end else begin
            r_in_q <= w_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Counter holds the number of consecutive edges on which the current
    // pattern was seen. The edge that brings it to STABLE_CYCLES evaluates.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_eval       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next   = 8'd1;
                w_state_next = ST_COUNT;
            end
            ST_COUNT: begin
                if (w_change) begin
                    w_cnt_next = 8'd1;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                    if (r_cnt + 8'd1 == c_STABLE) begin
                        w_eval       = 1'b1;
                        w_state_next = ST_HELD;
                    end
                end
            end
            ST_HELD: begin
                if (w_change) begin
                    w_cnt_next   = 8'd1;
                    w_state_next = ST_COUNT;
                end
            end
            default: begin
                w_cnt_next   = 8'd1;
                w_state_next = ST_COUNT;
            end
        endcase
    end

    // The digit that completes a frame clears seen together with the
    // frame_done pulse, so it is not counted toward the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hex    <= '0;
            r_dv     <= '0;
            r_seen   <= '0;
            r_bad    <= 1'b0;
            r_ghost  <= 1'b0;
            r_frame  <= 1'b0;
`ifdef SEVSEG_DP_CAPTURE_EN
            r_dp_out <= '0;
`endif
        end else begin
            r_bad   <= 1'b0;
            r_ghost <= 1'b0;
            r_frame <= 1'b0;
            if (w_eval && w_any) begin
                if (w_multi) begin
                    r_ghost <= 1'b1;
                end else if (w_dec_valid) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (w_low[i]) begin
                            r_hex[4*i +: 4] <= w_dec_hex;
`ifdef SEVSEG_DP_CAPTURE_EN
                            r_dp_out[i]     <= ~bus.dp;
`endif
                        end
                    end
                    r_dv <= r_dv | w_low;
                    if (&w_seen_upd) begin
                        r_seen  <= '0;
                        r_frame <= 1'b1;
                    end else begin
                        r_seen  <= w_seen_upd;
                    end
                end else begin
                    r_dv   <= r_dv & ~w_low;
                    r_seen <= r_seen & ~w_low;
                    r_bad  <= 1'b1;
                end
            end
        end
    end

    assign bus.hex_out     = r_hex;
    assign bus.digit_valid = r_dv;
    assign bus.bad_pattern = r_bad;
    assign bus.ghost_err   = r_ghost;
    assign bus.frame_done  = r_frame;
`ifdef SEVSEG_DP_CAPTURE_EN
    assign bus.dp_out      = r_dp_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_capture
// Description : Directed testbench for seven_seg_capture. It drives anode and
//               segment patterns and compares the outputs against values
//               worked out by hand. Set SEVSEG_DP_CAPTURE_EN to include the
//               decimal-point case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_capture;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;
    int   n_badp;
    int   n_ghost;
    int   n_frame;
    int   b0;
    int   g0;
    int   f0;
    logic [6:0] segtab [16];
    logic [7:0] a;

    seven_seg_capture_if #(.NUM_DIGITS(8)) bus ();

    seven_seg_capture #(
        .NUM_DIGITS    (8),
        .STABLE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts pulse-cycles. A pulse stuck high is counted more than once.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.bad_pattern) n_badp++;
            if (bus.ghost_err)   n_ghost++;
            if (bus.frame_done)  n_frame++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [7:0] an_v, input logic [6:0] seg_v);
        bus.an  = an_v;
        bus.seg = seg_v;
    endtask

    initial begin
        n_total = 0; n_bad = 0; n_badp = 0; n_ghost = 0; n_frame = 0;
        segtab[0]  = 7'b0000001; segtab[1]  = 7'b1001111;
        segtab[2]  = 7'b0010010; segtab[3]  = 7'b0000110;
        segtab[4]  = 7'b1001100; segtab[5]  = 7'b0100100;
        segtab[6]  = 7'b0100000; segtab[7]  = 7'b0001111;
        segtab[8]  = 7'b0000000; segtab[9]  = 7'b0001100;
        segtab[10] = 7'b0001000; segtab[11] = 7'b1100000;
        segtab[12] = 7'b0110001; segtab[13] = 7'b1000010;
        segtab[14] = 7'b0110000; segtab[15] = 7'b0111000;

        reset = 1'b1;
        drive(8'hFF, 7'h7F);
`ifdef SEVSEG_DP_CAPTURE_EN
        bus.dp = 1'b1;
`endif
        step(2);
        check("rst_hex",   bus.hex_out, 0);
        check("rst_dv",    bus.digit_valid, 0);
        check("rst_bad",   bus.bad_pattern, 0);
        check("rst_ghost", bus.ghost_err, 0);
        check("rst_frame", bus.frame_done, 0);
        reset = 1'b0;

        // First capture, then an async reset in the middle of the next count
        drive(8'hFE, 7'b0010010);
        step(3);
        check("pre_cap_dv", bus.digit_valid, 0);
        step(1);
        check("cap_hex", bus.hex_out, 32'h2);
        check("cap_dv",  bus.digit_valid, 8'h01);
        drive(8'hFD, 7'b1001111);
        step(2);
        #2 reset = 1'b1;
        #1;
        check("async_hex", bus.hex_out, 0);
        check("async_dv",  bus.digit_valid, 0);
        step(1);
        reset = 1'b0;

        // After release: capture lands exactly on edge 4
        drive(8'hFE, 7'b0010010);
        for (int e = 1; e <= 3; e++) begin
            step(1);
            check("edge_early_dv", bus.digit_valid, 0);
        end
        step(1);
        check("edge4_hex", bus.hex_out, 32'h2);
        check("edge4_dv",  bus.digit_valid, 8'h01);

        // Full scan: digits 0..7 get values 1..8
        f0 = n_frame;
        for (int d = 0; d < 8; d++) begin
            a = 8'd1 << d;
            drive(~a, segtab[d+1]);
            step(3);
            if (d == 7) check("frame_early", bus.frame_done, 0);
            step(1);
            if (d == 7) check("frame_edge", bus.frame_done, 1);
            step(1);
        end
        check("frame_count", n_frame - f0, 1);
        check("scan_hex",    bus.hex_out, 32'h87654321);
        check("scan_dv",     bus.digit_valid, 8'hFF);
        check("seen_clear",  dut.r_seen, 0);

        // Glitch restarts the count and the glitch value is never captured
        drive(8'hFD, 7'b1001111);
        step(3);
        drive(8'hFD, 7'b0000110);
        step(1);
        check("glitch_hold", bus.hex_out, 32'h87654321);
        drive(8'hFD, 7'b1001111);
        step(3);
        check("glitch_wait", bus.hex_out, 32'h87654321);
        step(1);
        check("glitch_cap",  bus.hex_out, 32'h87654311);

        // Blank pattern on slot 3
        b0 = n_badp;
        drive(8'hF7, 7'b1111111);
        step(6);
        check("bad_count", n_badp - b0, 1);
        check("bad_dv",    bus.digit_valid, 8'hF7);
        check("bad_hex",   bus.hex_out, 32'h87654311);

        // Two anodes low
        g0 = n_ghost;
        b0 = n_badp;
        drive(8'hFC, 7'b0000000);
        step(5);
        check("ghost_count", n_ghost - g0, 1);
        check("ghost_nobad", n_badp - b0, 0);
        check("ghost_hex",   bus.hex_out, 32'h87654311);
        check("ghost_dv",    bus.digit_valid, 8'hF7);

        // No anode low: nothing happens
        g0 = n_ghost; b0 = n_badp; f0 = n_frame;
        drive(8'hFF, 7'b0000000);
        step(5);
        check("idle_pulses", (n_ghost - g0) + (n_badp - b0) + (n_frame - f0), 0);
        check("idle_hex",    bus.hex_out, 32'h87654311);
        check("idle_dv",     bus.digit_valid, 8'hF7);

        // Re-capture slot 3 with A
        drive(8'hF7, segtab[10]);
        step(5);
        check("recap_hex", bus.hex_out, 32'h8765A311);
        check("recap_dv",  bus.digit_valid, 8'hFF);

`ifdef SEVSEG_DP_CAPTURE_EN
        drive(8'hBF, 7'b0001000);
        bus.dp = 1'b0;
        step(4);
        check("dp_hex", bus.hex_out, 32'h8A65A311);
        check("dp_out", bus.dp_out[6], 1);
        bus.dp = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
